instr_mem_loader: RTL and testbench

//  Write-side companion of the instruction memory read by the single-cycle datapath.

---
 rtl/instr_mem_loader_if.sv | 22 ++
 rtl/instr_mem_loader.sv | 185 ++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The slave side is the loader; the master side is whoever feeds bytes and owns the memory.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 32
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Loads a program image (count byte + big-endian words) into instruction memory
// while holding the CPU; all outputs are registered.
module instr_mem_loader #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
  parameter int                MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  instr_mem_loader_if.slave bus,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [7:0]        words_loaded
);

  localparam logic [7:0] MAX_LIMIT = 8'(MAX_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_BYTES = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic              accept_s;
  logic              rx_ready_r;
  logic              mem_we_r;
  logic              cpu_hold_r;
  logic              load_done_r;
  logic              load_error_r;
  logic              rx_ready_nxt_s;
  logic              mem_we_nxt_s;
  logic              cpu_hold_nxt_s;
  logic              load_done_nxt_s;
  logic [7:0]        word_cnt_r;
  logic [7:0]        rcv_cnt_r;
  logic [7:0]        words_loaded_r;
  logic [1:0]        byte_idx_r;
  logic [23:0]       shift_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;

  assign accept_s = bus.rx_valid & rx_ready_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (load_start) next_state_s = ST_HDR;
        else            next_state_s = state_r;
      end
      ST_HDR: begin
        if (!accept_s)                next_state_s = ST_HDR;
        else if (bus.rx_data == 8'd0) next_state_s = ST_DONE;
        else                          next_state_s = ST_BYTES;
      end
      ST_BYTES: begin
        if (accept_s && (byte_idx_r == 2'd3)) next_state_s = ST_WRITE;
        else                                  next_state_s = ST_BYTES;
      end
      ST_WRITE: begin
        if ((rcv_cnt_r + 8'd1) == word_cnt_r) next_state_s = ST_DONE;
        else                                  next_state_s = ST_BYTES;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state, so the registered outputs line up with it
  always_comb begin
    rx_ready_nxt_s  = 1'b0;
    mem_we_nxt_s    = 1'b0;
    cpu_hold_nxt_s  = 1'b0;
    load_done_nxt_s = 1'b0;
    case (next_state_s)
      ST_HDR, ST_BYTES: begin
        rx_ready_nxt_s = 1'b1;
        cpu_hold_nxt_s = 1'b1;
      end
      ST_WRITE: begin
        cpu_hold_nxt_s = 1'b1;
        mem_we_nxt_s   = ~load_error_r;
      end
      ST_DONE: begin
        load_done_nxt_s = 1'b1;
      end
      default: begin
        rx_ready_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      cpu_hold_r  <= 1'b0;
      load_done_r <= 1'b0;
    end else begin
      rx_ready_r  <= rx_ready_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      cpu_hold_r  <= cpu_hold_nxt_s;
      load_done_r <= load_done_nxt_s;
    end
  end

  // Header capture, word assembly, address and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt_r     <= 8'd0;
      rcv_cnt_r      <= 8'd0;
      words_loaded_r <= 8'd0;
      byte_idx_r     <= 2'd0;
      shift_r        <= 24'd0;
      mem_addr_r     <= BASE_ADDR;
      mem_wdata_r    <= 32'd0;
      load_error_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (load_start) begin
            rcv_cnt_r      <= 8'd0;
            words_loaded_r <= 8'd0;
            byte_idx_r     <= 2'd0;
            mem_addr_r     <= BASE_ADDR;
            load_error_r   <= 1'b0;
          end
        end
        ST_HDR: begin
          if (accept_s) begin
            word_cnt_r   <= bus.rx_data;
            load_error_r <= (bus.rx_data > MAX_LIMIT);
          end
        end
        ST_BYTES: begin
          if (accept_s) begin
            if (byte_idx_r == 2'd3) begin
              mem_wdata_r <= {shift_r, bus.rx_data};
              byte_idx_r  <= 2'd0;
            end else begin
              shift_r    <= {shift_r[15:0], bus.rx_data};
              byte_idx_r <= byte_idx_r + 2'd1;
            end
          end
        end
        ST_WRITE: begin
          // Error loads still walk the address so the byte count stays honest
          mem_addr_r <= mem_addr_r + ADDR_W'(4);
          rcv_cnt_r  <= rcv_cnt_r + 8'd1;
          if (!load_error_r) words_loaded_r <= words_loaded_r + 8'd1;
          else               words_loaded_r <= words_loaded_r;
        end
        default: begin
          byte_idx_r <= 2'd0;
        end
      endcase
    end
  end

  assign bus.rx_ready  = rx_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign cpu_hold      = cpu_hold_r;
  assign load_done     = load_done_r;
  assign load_error    = load_error_r;
  assign words_loaded  = words_loaded_r;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: images are fed with varying rx_valid patterns and
// the captured memory writes are compared with the writes the image itself implies.
module tb_instr_mem_loader;
  localparam int                ADDR_W = 32;
  localparam logic [ADDR_W-1:0] BASE   = 32'h0000_0000;
  localparam int                MAXW   = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic       cpu_hold;
  logic       load_done;
  logic       load_error;
  logic [7:0] words_loaded;

  instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_mem_loader #(
    .ADDR_W(ADDR_W),
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_start(load_start),
    .bus(bus),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          acc_cnt = 0;
  logic [7:0]  img_q[$];
  logic [31:0] got_addr_q[$];
  logic [31:0] got_data_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Capture memory writes and byte handshakes mid-cycle
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      got_addr_q.push_back(bus.mem_addr);
      got_data_q.push_back(bus.mem_wdata);
    end
    if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) acc_cnt++;
  end

  task automatic build_rand(input int n);
    img_q.delete();
    img_q.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) img_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  // mode 0: always valid, 1: toggle each cycle, 2: random; pulse_cyc<0 means no stray start
  task automatic feed(input int mode, input int pulse_cyc);
    int idx = 0;
    int cyc = 0;
    while (idx < img_q.size() && cyc < 4000) begin
      case (mode)
        0:       bus.rx_valid = 1'b1;
        1:       bus.rx_valid = ((cyc % 2) == 0);
        default: bus.rx_valid = ($urandom_range(0, 3) != 0);
      endcase
      bus.rx_data = img_q[idx];
      load_start  = (cyc == pulse_cyc);
      @(negedge clk);
      if (bus.rx_valid && bus.rx_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    load_start = 1'b0;
    check_val("feed_all_bytes", 64'(idx), 64'(img_q.size()));
  endtask

  task automatic run_load(input int mode, input int pulse_cyc);
    int          n;
    int          nw;
    int          a0;
    int          w0;
    int          waits;
    logic [31:0] w;
    n  = int'(img_q[0]);
    nw = (n <= MAXW) ? n : 0;
    a0 = acc_cnt;
    w0 = got_addr_q.size();
    start_load();
    check_val("hold_after_start", 64'(cpu_hold), 64'd1);
    check_val("done_cleared", 64'(load_done), 64'd0);
    check_val("words_cleared", 64'(words_loaded), 64'd0);
    feed(mode, pulse_cyc);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    waits = 0;
    while (load_done !== 1'b1 && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check_val("load_done", 64'(load_done), 64'd1);
    check_val("load_error", 64'(load_error), 64'(n > MAXW));
    check_val("words_loaded", 64'(words_loaded), 64'(nw));
    check_val("hold_in_done", 64'(cpu_hold), 64'd0);
    check_val("bytes_taken", 64'(acc_cnt - a0), 64'(1 + 4 * n));
    check_val("num_writes", 64'(got_addr_q.size() - w0), 64'(nw));
    for (int i = 0; i < nw && (w0 + i) < got_addr_q.size(); i++) begin
      w = {img_q[1 + 4 * i], img_q[2 + 4 * i], img_q[3 + 4 * i], img_q[4 + 4 * i]};
      check_val("write_addr", 64'(got_addr_q[w0 + i]), 64'(BASE + 32'(4 * i)));
      check_val("write_data", 64'(got_data_q[w0 + i]), 64'(w));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    int w0;
    reset        = 1'b1;
    load_start   = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check_val("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check_val("rst_mem_addr", 64'(bus.mem_addr), 64'(BASE));
    check_val("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check_val("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    check_val("rst_load_done", 64'(load_done), 64'd0);
    check_val("rst_load_error", 64'(load_error), 64'd0);
    check_val("rst_words", 64'(words_loaded), 64'd0);
    @(posedge clk); #1;

    // Reset while two payload bytes of a 3-word image are in
    img_q = {8'd3, 8'h11, 8'h22};
    start_load();
    feed(0, -1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("midrst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check_val("midrst_cpu_hold", 64'(cpu_hold), 64'd0);
    check_val("midrst_mem_addr", 64'(bus.mem_addr), 64'(BASE));
    a0 = acc_cnt;
    w0 = got_addr_q.size();
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h33;
    repeat (10) begin
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check_val("midrst_no_write", 64'(got_addr_q.size() - w0), 64'd0);
    check_val("midrst_no_accept", 64'(acc_cnt - a0), 64'd0);
    @(posedge clk); #1;

    // Known two-word image, then the same with rx_valid toggling
    img_q = {8'd2, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    run_load(0, -1);
    check_val("known_word1", 64'(got_data_q[got_data_q.size() - 1]), 64'h8C09_0004);
    run_load(1, -1);

    // Empty image and an oversize image
    build_rand(0);
    run_load(0, -1);
    build_rand(MAXW + 1);
    run_load(2, -1);

    // Full image with a stray start during BYTES, then a reload from DONE
    build_rand(MAXW);
    run_load(0, 20);
    check_val("last_addr", 64'(got_addr_q[got_addr_q.size() - 1]), 64'(BASE + 32'd252));
    build_rand(3);
    run_load(2, -1);

    for (int k = 0; k < 6; k++) begin
      build_rand($urandom_range(1, 12));
      run_load(2, -1);
    end
    build_rand($urandom_range(MAXW + 1, MAXW + 6));
    run_load(2, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
